// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and controller state type.
package vga_timing_pkg;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam int unsigned DEF_CLK_DIV   = 4;

   localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// 10-bit wrapping axis counter with increment enable, synchronous clear and terminal count.
module vga_axis_counter #(
   parameter int unsigned MAX = 800
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output logic [9:0] count,
   output logic [9:0] count_next,
   output logic       tc
);

   logic [9:0] count_q;
   logic [9:0] count_d;

   assign tc = (count_q == 10'(MAX - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = tc ? '0 : count_q + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing generator: pixel-rate divider, x/y counters, syncs and start pulses, with
// a drain state so a stop request always completes the current frame.
module vga_timing_controller
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start,
   output logic       busy
);

   localparam int unsigned H_LEN  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_LEN  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_BEG = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END = VS_BEG + V_SYNC;
   localparam int unsigned DIV_W  = $clog2(CLK_DIV);

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   logic               tick, wrap, x_tc, y_tc, cnt_clear;
   logic [9:0]         x_next, y_next;

   assign cnt_clear = (state_q == IDLE);

   vga_axis_counter #(.MAX(H_LEN)) u_x_cnt (
      .clk        (Clk),
      .reset      (reset),
      .clear      (cnt_clear),
      .inc        (tick),
      .count      (pixel_x),
      .count_next (x_next),
      .tc         (x_tc)
   );

   vga_axis_counter #(.MAX(V_LEN)) u_y_cnt (
      .clk        (Clk),
      .reset      (reset),
      .clear      (cnt_clear),
      .inc        (tick && x_tc),
      .count      (pixel_y),
      .count_next (y_next),
      .tc         (y_tc)
   );

   always_comb begin
      tick = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
      wrap = tick && x_tc && y_tc;

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = DRAIN;
         DRAIN:   if (enable) state_d = RUN;
                  else if (wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      div_d = '0;
      if (state_q != IDLE && state_d != IDLE && !tick) begin
         div_d = div_q + DIV_W'(1);
      end

      // Decoded from next-count values so syncs move on the same edge as the counters.
      hsync_d       = 1'b1;
      vsync_d       = 1'b1;
      video_on_d    = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (state_d != IDLE) begin
         hsync_d       = !(x_next >= 10'(HS_BEG) && x_next < 10'(HS_END));
         vsync_d       = !(y_next >= 10'(VS_BEG) && y_next < 10'(VS_END));
         video_on_d    = (x_next < 10'(H_VISIBLE)) && (y_next < 10'(V_VISIBLE));
         line_start_d  = (state_q == IDLE) || (tick && x_tc);
         frame_start_d = (state_q == IDLE) || wrap;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q       <= IDLE;
         div_q         <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pixel_tick  = tick;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a reduced-geometry instance checked every cycle against a
// position/phase reference model, plus a default 640x480 instance checked over one line.
module tb_vga_timing_controller;

   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
   localparam int SVV = 5, SVF = 1, SVS = 2, SVB = 2;
   localparam int SD  = 3;
   localparam int SHT = SHV + SHF + SHS + SHB;
   localparam int SVT = SVV + SVF + SVS + SVB;
   localparam int SF  = SHT * SVT * SD;

   typedef struct packed {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       ls;
      logic       fs;
      logic       busy;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic       s_reset = 1'b1, s_en = 1'b0;
   logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_busy;
   logic [9:0] s_x, s_y;

   logic       d_reset = 1'b1, d_en = 1'b0;
   logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs, d_busy;
   logic [9:0] d_x, d_y;

   vga_timing_controller #(
      .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .CLK_DIV(SD)
   ) u_small (
      .Clk(clk), .reset(s_reset), .enable(s_en), .pixel_tick(s_tick),
      .pixel_x(s_x), .pixel_y(s_y), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
      .line_start(s_ls), .frame_start(s_fs), .busy(s_busy)
   );

   vga_timing_controller u_dflt (
      .Clk(clk), .reset(d_reset), .enable(d_en), .pixel_tick(d_tick),
      .pixel_x(d_x), .pixel_y(d_y), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
      .line_start(d_ls), .frame_start(d_fs), .busy(d_busy)
   );

   // Reference model: state, sub-pixel phase and linear frame position.
   int   m_st = 0, m_ph = 0, m_pos = 0;
   logic m_ls = 1'b0, m_fs = 1'b0;
   obs_t sb[$];

   always @(posedge clk) begin
      obs_t e;
      int   mx, my;
      logic act;
      if (s_reset) begin
         m_st = 0; m_ph = 0; m_pos = 0; m_ls = 1'b0; m_fs = 1'b0;
      end else if (m_st == 0) begin
         m_ph = 0; m_pos = 0; m_ls = s_en; m_fs = s_en;
         if (s_en) m_st = 1;
      end else begin
         m_ls = 1'b0; m_fs = 1'b0;
         if (m_ph == SD - 1) begin
            m_ph  = 0;
            m_pos = (m_pos + 1) % (SHT * SVT);
            if (m_pos % SHT == 0) m_ls = 1'b1;
            if (m_pos == 0) begin
               if (m_st == 2 && !s_en) begin
                  m_st = 0; m_ls = 1'b0;
               end else begin
                  m_fs = 1'b1;
               end
            end
         end else begin
            m_ph++;
         end
         if (m_st == 1 && !s_en) m_st = 2;
         else if (m_st == 2 && s_en) m_st = 1;
      end
      mx  = m_pos % SHT;
      my  = m_pos / SHT;
      act = (m_st != 0);
      e.tick = act && (m_ph == SD - 1);
      e.x    = 10'(mx);
      e.y    = 10'(my);
      e.hs   = !(act && mx >= SHV + SHF && mx < SHV + SHF + SHS);
      e.vs   = !(act && my >= SVV + SVF && my < SVV + SVF + SVS);
      e.von  = act && mx < SHV && my < SVV;
      e.ls   = m_ls;
      e.fs   = m_fs;
      e.busy = act;
      sb.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e, a;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         a = {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_ls, s_fs, s_busy};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL scoreboard t=%0t got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b busy=%b, expected tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b busy=%b",
                     $time, a.tick, a.x, a.y, a.hs, a.vs, a.von, a.ls, a.fs, a.busy,
                     e.tick, e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs, e.busy);
         end
      end
   end

   task automatic test_reset();
      s_reset = 1'b1; s_en = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({s_busy, s_hs, s_vs, s_von, s_tick, s_ls, s_fs, s_x, s_y} !== {7'b0110000, 20'd0}) begin
         n_err++;
         $display("FAIL reset_values got busy=%b hs=%b vs=%b von=%b tick=%b ls=%b fs=%b x=%0d y=%0d, expected 0 1 1 0 0 0 0 0 0",
                  s_busy, s_hs, s_vs, s_von, s_tick, s_ls, s_fs, s_x, s_y);
      end
      s_reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({s_busy, s_tick, s_hs, s_x} !== {3'b001, 10'd0}) begin
         n_err++;
         $display("FAIL idle_hold got busy=%b tick=%b hs=%b x=%0d, expected 0 0 1 0", s_busy, s_tick, s_hs, s_x);
      end
   endtask

   task automatic test_start();
      int first_tick = 0, second_tick = 0;
      s_en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_cmp++;
            if ({s_busy, s_fs, s_ls} !== 3'b111) begin
               n_err++;
               $display("FAIL start_pulses got busy=%b fs=%b ls=%b, expected 1 1 1", s_busy, s_fs, s_ls);
            end
         end
         if (k == 2) begin
            n_cmp++;
            if ({s_fs, s_ls} !== 2'b00) begin
               n_err++;
               $display("FAIL start_width got fs=%b ls=%b, expected 0 0", s_fs, s_ls);
            end
         end
         if (s_tick && first_tick != 0 && second_tick == 0) second_tick = k;
         if (s_tick && first_tick == 0) first_tick = k;
      end
      n_cmp++;
      if (first_tick != SD || second_tick != 2 * SD) begin
         n_err++;
         $display("FAIL tick_timing got first=%0d second=%0d, expected %0d %0d", first_tick, second_tick, SD, 2 * SD);
      end
   endtask

   task automatic test_frames();
      int nfs = 0, nls = 0, nover = 0, nvs = 0, nhs = 0, nvo = 0, guard = 0;
      while (!s_fs && guard < 2 * SF) begin
         @(negedge clk); guard++;
      end
      n_cmp++;
      if (!s_fs) begin
         n_err++;
         $display("FAIL frame_wait got fs=0 after %0d cycles, expected a frame_start", guard);
      end
      for (int c = 0; c < 3 * SF; c++) begin
         if (s_fs) nfs++;
         if (s_ls) nls++;
         if (s_x >= 10'(SHT)) nover++;
         if (!s_vs) nvs++;
         if (!s_hs) nhs++;
         if (s_von) nvo++;
         @(negedge clk);
      end
      n_cmp++;
      if (nfs != 3 || nls != 3 * SVT || nover != 0) begin
         n_err++;
         $display("FAIL three_frames got fs=%0d ls=%0d x_over=%0d, expected 3 %0d 0", nfs, nls, nover, 3 * SVT);
      end
      n_cmp++;
      if (nvs != 3 * SVS * SHT * SD || nhs != 3 * SHS * SVT * SD || nvo != 3 * SHV * SVV * SD) begin
         n_err++;
         $display("FAIL sync_widths got vs_low=%0d hs_low=%0d von=%0d, expected %0d %0d %0d",
                  nvs, nhs, nvo, 3 * SVS * SHT * SD, 3 * SHS * SVT * SD, 3 * SHV * SVV * SD);
      end
   endtask

   task automatic test_drain();
      int guard = 0, px = 0, py = 0, nlow = 0, njump = 0, prev, cur;
      while (s_y != 10'd2 && guard < SF) begin
         @(negedge clk); guard++;
      end
      s_en = 1'b0;
      guard = 0;
      while (s_busy && guard < 2 * SF) begin
         px = s_x; py = s_y;
         @(negedge clk); guard++;
      end
      n_cmp++;
      if (s_busy || px != SHT - 1 || py != SVT - 1) begin
         n_err++;
         $display("FAIL drain_end got busy=%b last=(%0d,%0d), expected 0 (%0d,%0d)", s_busy, px, py, SHT - 1, SVT - 1);
      end
      n_cmp++;
      if ({s_hs, s_vs, s_von, s_fs, s_x, s_y} !== {4'b1100, 20'd0}) begin
         n_err++;
         $display("FAIL drain_idle got hs=%b vs=%b von=%b fs=%b x=%0d y=%0d, expected 1 1 0 0 0 0",
                  s_hs, s_vs, s_von, s_fs, s_x, s_y);
      end
      s_en = 1'b1;
      guard = 0;
      while (s_y != 10'd3 && guard < 2 * SF) begin
         @(negedge clk); guard++;
      end
      s_en = 1'b0;
      while (s_y != 10'd6 && guard < 3 * SF) begin
         @(negedge clk); guard++;
      end
      s_en = 1'b1;
      prev = int'(s_y) * SHT + int'(s_x);
      for (int c = 0; c < SF; c++) begin
         @(negedge clk);
         if (!s_busy) nlow++;
         cur = int'(s_y) * SHT + int'(s_x);
         if (cur != prev && cur != (prev + 1) % (SHT * SVT)) njump++;
         prev = cur;
      end
      n_cmp++;
      if (nlow != 0 || njump != 0 || guard >= 3 * SF) begin
         n_err++;
         $display("FAIL drain_resume got busy_low=%0d jumps=%0d guard=%0d, expected 0 0 <%0d", nlow, njump, guard, 3 * SF);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while (!(s_x == 10'd7 && s_y == 10'd3) && guard < 2 * SF) begin
         @(negedge clk); guard++;
      end
      s_reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_busy, s_hs, s_vs, s_von, s_tick, s_ls, s_fs, s_x, s_y} !== {7'b0110000, 20'd0} || guard >= 2 * SF) begin
         n_err++;
         $display("FAIL mid_reset got busy=%b hs=%b vs=%b von=%b tick=%b x=%0d y=%0d guard=%0d, expected 0 1 1 0 0 0 0",
                  s_busy, s_hs, s_vs, s_von, s_tick, s_x, s_y, guard);
      end
      s_reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({s_busy, s_fs, s_ls, s_x, s_y} !== {3'b111, 20'd0}) begin
         n_err++;
         $display("FAIL mid_restart got busy=%b fs=%b ls=%b x=%0d y=%0d, expected 1 1 1 0 0",
                  s_busy, s_fs, s_ls, s_x, s_y);
      end
      repeat (2 * SHT * SD) @(negedge clk);
   endtask

   task automatic test_default_line();
      int first_tick = 0, hs_fall_x = -1, hs_rise_x = -1, von_fall_x = -1;
      int hs_low = 0, max_x = 0, wrap_cyc = 0, wrap_y = -1;
      logic prev_hs = 1'b1, prev_von = 1'b0;
      @(negedge clk);
      d_reset = 1'b0;
      @(negedge clk);
      d_en = 1'b1;
      for (int cyc = 1; cyc <= 3300; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            n_cmp++;
            if ({d_busy, d_fs, d_ls, d_von} !== 4'b1111) begin
               n_err++;
               $display("FAIL dflt_start got busy=%b fs=%b ls=%b von=%b, expected 1 1 1 1", d_busy, d_fs, d_ls, d_von);
            end
         end
         if (d_tick && first_tick == 0) first_tick = cyc;
         if (prev_hs && !d_hs) hs_fall_x = d_x;
         if (!prev_hs && d_hs && hs_rise_x < 0) hs_rise_x = d_x;
         if (prev_von && !d_von && von_fall_x < 0) von_fall_x = d_x;
         if (!d_hs) hs_low++;
         if (int'(d_x) > max_x) max_x = d_x;
         if (cyc > 1 && d_ls && wrap_cyc == 0) begin
            wrap_cyc = cyc; wrap_y = d_y;
         end
         prev_hs = d_hs; prev_von = d_von;
      end
      n_cmp++;
      if (first_tick != 4) begin
         n_err++;
         $display("FAIL dflt_first_tick got %0d, expected 4", first_tick);
      end
      n_cmp++;
      if (hs_fall_x != 656 || hs_rise_x != 752 || hs_low != 384) begin
         n_err++;
         $display("FAIL dflt_hsync got fall_x=%0d rise_x=%0d low=%0d, expected 656 752 384", hs_fall_x, hs_rise_x, hs_low);
      end
      n_cmp++;
      if (von_fall_x != 640) begin
         n_err++;
         $display("FAIL dflt_video_on got fall_x=%0d, expected 640", von_fall_x);
      end
      n_cmp++;
      if (max_x != 799 || wrap_cyc != 3201 || wrap_y != 1) begin
         n_err++;
         $display("FAIL dflt_line got max_x=%0d wrap_cyc=%0d wrap_y=%0d, expected 799 3201 1", max_x, wrap_cyc, wrap_y);
      end
      d_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_frames();
      test_drain();
      test_reset_mid();
      test_default_line();
      s_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
